// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready payload + control bundle with an
// optional 2-entry skid buffer, NOP-on-flush bubbles and saturating profiling counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned CTRL_WIDTH = 16,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  starve_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  state_t                state_nx;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  push;
  logic                  pop;
  logic                  load_main;
  logic                  load_skid;
  logic                  main_from_skid;

  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // in_ready: registered from the next state with a skid buffer, otherwise
  // combinational so a full single register can still refill on a pop.
  if (SKID != 0) begin : g_skid
    logic ready_q;
    always_ff @(posedge clk) begin
      if (!rst) ready_q <= 1'b0;
      else      ready_q <= (state_nx != TWO);
    end
    assign in_ready = ready_q;
  end else begin : g_noskid
    assign in_ready = rst & (~out_valid | out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nx  = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_nx  = TWO;
          load_skid = 1'b1;
        end else if (push && pop) begin
          load_main = 1'b1;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nx       = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // Flush discards everything, including a push in the same cycle.
    if (flush) begin
      state_nx       = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // Payload registers; cleared on reset and flush so bubbles carry a NOP.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (main_from_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // Profiling counters keep running through flush cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (!out_valid && out_ready && starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid build (4-bit counters) and a no-skid build share
// the stimulus; each is checked against a FIFO-level reference model every cycle.
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [15:0]  in_ctrl;
  logic [95:0]  in_data;

  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [15:0]  out_ctrl0, out_ctrl1;
  logic [95:0]  out_data0, out_data1;
  logic [1:0]   occ0, occ1;
  logic [3:0]   stall0, starve0;
  logic [15:0]  stall1, starve1;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_WIDTH(96), .CTRL_WIDTH(16), .SKID(1), .CNT_WIDTH(4)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0),
    .stall_cnt(stall0), .starve_cnt(starve0)
  );

  pipe_stage_reg #(.DATA_WIDTH(96), .CTRL_WIDTH(16), .SKID(0), .CNT_WIDTH(16)) dut_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1),
    .stall_cnt(stall1), .starve_cnt(starve1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: k=0 is the skid build (capacity 2), k=1 the plain register (capacity 1).
  typedef struct {
    logic [15:0] c;
    logic [95:0] d;
  } beat_t;

  beat_t       fifo [2][2];
  int          sz [2];
  logic [95:0] md [2];
  int          stall [2];
  int          starve [2];
  int          cmax [2];
  bit          rdy_reg;

  function automatic bit exp_rdy(int k);
    if (k == 0) return rdy_reg;
    return rst && (sz[1] == 0 || out_ready);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit ov, push, pop;
      if (!rst) begin
        sz[k] = 0; md[k] = '0; stall[k] = 0; starve[k] = 0;
        if (k == 0) rdy_reg = 1'b0;
      end else begin
        ov   = (sz[k] > 0);
        push = in_valid && exp_rdy(k);
        pop  = ov && out_ready;
        if (ov && !out_ready && stall[k] < cmax[k]) stall[k]++;
        if (!ov && out_ready && starve[k] < cmax[k]) starve[k]++;
        if (flush) begin
          sz[k] = 0; md[k] = '0;
        end else begin
          if (pop) begin
            fifo[k][0] = fifo[k][1];
            sz[k]--;
          end
          if (push) begin
            fifo[k][sz[k]].c = in_ctrl;
            fifo[k][sz[k]].d = in_data;
            sz[k]++;
          end
          if (sz[k] > 0) md[k] = fifo[k][0].d;
        end
        if (k == 0) rdy_reg = (sz[0] < 2);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [127:0] ectrl;
      ectrl = (sz[k] > 0) ? 128'(fifo[k][0].c) : 128'(0);
      if (k == 0) begin
        chk("skid out_valid", 128'(out_valid0), 128'(sz[0] > 0));
        chk("skid out_ctrl",  128'(out_ctrl0),  ectrl);
        chk("skid out_data",  128'(out_data0),  128'(md[0]));
        chk("skid occupancy", 128'(occ0),       128'(sz[0]));
        chk("skid stall_cnt", 128'(stall0),     128'(stall[0]));
        chk("skid starve_cnt", 128'(starve0),   128'(starve[0]));
        chk("skid in_ready",  128'(in_ready0),  128'(exp_rdy(0)));
      end else begin
        chk("noskid out_valid", 128'(out_valid1), 128'(sz[1] > 0));
        chk("noskid out_ctrl",  128'(out_ctrl1),  ectrl);
        chk("noskid out_data",  128'(out_data1),  128'(md[1]));
        chk("noskid occupancy", 128'(occ1),       128'(sz[1]));
        chk("noskid stall_cnt", 128'(stall1),     128'(stall[1]));
        chk("noskid starve_cnt", 128'(starve1),   128'(starve[1]));
        chk("noskid in_ready",  128'(in_ready1),  128'(exp_rdy(1)));
      end
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [15:0] c,
                     input logic [95:0] d, input bit ordy);
    rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [95:0] rd;
    cmax[0] = 15;
    cmax[1] = 65535;
    sz[0] = 0; sz[1] = 0; rdy_reg = 1'b0;
    md[0] = '0; md[1] = '0;
    stall[0] = 0; stall[1] = 0; starve[0] = 0; starve[1] = 0;

    // Reset held with a beat offered upstream.
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 96'hABCD, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 96'h0, 1'b0);

    // Streaming with downstream always ready.
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 96'h0, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, 16'(i + 16'h100), 96'(i), 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 96'h0, 1'b1);

    // Backpressure: A, B fill the stage, C waits until space returns.
    cyc(1'b1, 1'b0, 1'b1, 16'h00A1, 96'hA, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h00B2, 96'hB, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h00C3, 96'hC, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h00C3, 96'hC, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 16'h00C3, 96'hC, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0, 96'h0, 1'b1);

    // Flush at occupancy 2 with simultaneous push D and pop, then push E.
    cyc(1'b1, 1'b0, 1'b1, 16'h0011, 96'h11, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h0022, 96'h22, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'h00DD, 96'hDD, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h00EE, 96'hEE, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 96'h0, 1'b1);

    // Stall counter saturation on the 4-bit build.
    cyc(1'b1, 1'b0, 1'b1, 16'h0F0F, 96'h5A5A, 1'b0);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 16'h0, 96'h0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 96'h0, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      rd = {$urandom(), $urandom(), $urandom()};
      cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) != 0), 16'($urandom()), rd,
          ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
